// File: rtl/ps2_host_txrx.sv
// ---------------------------------------------------------------------------
// ps2_host_txrx
//
// PS/2 host transceiver.
// - Receives device-to-host frames into a show-ahead RX FIFO.
// - Transmits host-to-device bytes using the inhibit/request sequence.
// - Guards every frame with a watchdog.
// Both pads are open-drain: each is driven either 0 or Z.
//
// The optional macro PS2_ERR_COUNT_EN builds a saturating 8-bit error counter
// on err_cnt. Without the macro, err_cnt is tied to zero.
//
// Ports
//   CLK, RST            system clock (rising edge); async active-low reset
//   PS2CLK, PS2DATA     open-drain PS/2 lines
//   datain, tx_write    byte to send and its request (taken only when idle)
//   tx_busy             FSM not idle
//   tx_done, tx_err     one-cycle TX outcome pulses
//   dataout, rx_valid   FIFO head (show-ahead) and non-empty flag
//   rx_read             pop the FIFO head
//   rx_done, rx_err     one-cycle RX outcome pulses
//   fifo_count          FIFO occupancy
//   overflow            sticky: a good frame was dropped on a full FIFO
//   err_cnt             error counter (PS2_ERR_COUNT_EN) or 8'h00
// ---------------------------------------------------------------------------
module ps2_host_txrx #(
  parameter int CLK_HZ     = 50000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 2000,
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  inout  wire                         PS2CLK,
  inout  wire                         PS2DATA,
  input  logic [7:0]                  datain,
  input  logic                        tx_write,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        tx_err,
  output logic [7:0]                  dataout,
  output logic                        rx_valid,
  input  logic                        rx_read,
  output logic                        rx_done,
  output logic                        rx_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [7:0]                  err_cnt
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = AW + 1;
  localparam int          FLW     = $clog2(FILTER_LEN + 1);
  localparam logic [31:0] INH_CYC = 32'((CLK_HZ / 1000000) * INHIBIT_US);
  localparam logic [31:0] TO_CYC  = 32'((CLK_HZ / 1000000) * TIMEOUT_US);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_TX_INH, S_TX_REQ, S_TX_BITS, S_TX_ACK, S_TX_END
  } state_t;

  state_t         st_q, st_d;
  logic [1:0]     clk_sync_q, dat_sync_q;
  logic [FLW-1:0] flt_cnt_q, flt_cnt_d;
  logic           flt_q, flt_d, flt_prev_q;
  logic [3:0]     bit_q, bit_d;
  logic [31:0]    wd_q, wd_d;
  logic           clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic           tx_done_q, tx_done_d, tx_err_q, tx_err_d;
  logic           rx_done_q, rx_done_d, rx_err_q, rx_err_d;
  logic           clk_s, dat_s, fe, timeout;
  logic           latch_tx, rx_shift, rx_par_ld, rx_push;
  logic [8:0]     tx_sr_q;
  logic [7:0]     rx_sr_q;
  logic           rx_par_q;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q;
  logic           ovf_q, pop, full, push_ok;

  assign PS2CLK  = clk_oe_q ? 1'b0 : 1'bz;
  assign PS2DATA = dat_oe_q ? 1'b0 : 1'bz;

  assign clk_s   = clk_sync_q[1];
  assign dat_s   = dat_sync_q[1];
  assign fe      = flt_prev_q & ~flt_q;
  assign timeout = (st_q != S_IDLE) && (wd_q == TO_CYC - 32'd1);

  // ---- stage: input conditioning (sync + glitch filter) ----
  always_comb begin
    flt_cnt_d = '0;
    flt_d     = flt_q;
    if (clk_s != flt_q) begin
      if (flt_cnt_q == FLW'(FILTER_LEN - 1)) flt_d = clk_s;
      else                                   flt_cnt_d = flt_cnt_q + FLW'(1);
    end
  end

  // ---- stage: protocol FSM ----
  always_comb begin
    st_d      = st_q;
    bit_d     = bit_q;
    wd_d      = (st_q == S_IDLE) ? 32'd0 : wd_q + 32'd1;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    tx_done_d = 1'b0;
    tx_err_d  = 1'b0;
    rx_done_d = 1'b0;
    rx_err_d  = 1'b0;
    latch_tx  = 1'b0;
    rx_shift  = 1'b0;
    rx_par_ld = 1'b0;
    rx_push   = 1'b0;
    if (timeout) begin
      st_d     = S_IDLE;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      if (st_q == S_RX) rx_err_d = 1'b1;
      else              tx_err_d = 1'b1;
    end else begin
      case (st_q)
        S_IDLE: begin
          // A device start bit takes priority over a host transmit request.
          if (fe && !dat_s) begin
            st_d  = S_RX;
            bit_d = 4'd0;
          end else if (tx_write) begin
            latch_tx = 1'b1;
            clk_oe_d = 1'b1;
            st_d     = S_TX_INH;
          end
        end
        S_RX: begin
          if (fe) begin
            bit_d = bit_q + 4'd1;
            if (bit_q < 4'd8)       rx_shift  = 1'b1;
            else if (bit_q == 4'd8) rx_par_ld = 1'b1;
            else begin
              st_d = S_IDLE;
              if (dat_s && (^{rx_sr_q, rx_par_q})) begin
                rx_push   = 1'b1;
                rx_done_d = 1'b1;
              end else begin
                rx_err_d  = 1'b1;
              end
            end
          end
        end
        S_TX_INH: begin
          // The watchdog doubles as the inhibit timer: it starts at 0 here.
          if (wd_q == INH_CYC - 32'd1) begin
            dat_oe_d = 1'b1;
            st_d     = S_TX_REQ;
          end
        end
        S_TX_REQ: begin
          clk_oe_d = 1'b0;
          bit_d    = 4'd0;
          st_d     = S_TX_BITS;
        end
        S_TX_BITS: begin
          if (fe) begin
            if (bit_q == 4'd9) begin
              dat_oe_d = 1'b0;
              st_d     = S_TX_ACK;
            end else begin
              dat_oe_d = ~tx_sr_q[bit_q];
              bit_d    = bit_q + 4'd1;
            end
          end
        end
        S_TX_ACK: begin
          if (fe) begin
            if (!dat_s) st_d = S_TX_END;
            else begin
              tx_err_d = 1'b1;
              st_d     = S_IDLE;
            end
          end
        end
        S_TX_END: begin
          if (flt_q && dat_s) begin
            tx_done_d = 1'b1;
            st_d      = S_IDLE;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      flt_cnt_q  <= '0;
      flt_q      <= 1'b1;
      flt_prev_q <= 1'b1;
      st_q       <= S_IDLE;
      bit_q      <= 4'd0;
      wd_q       <= 32'd0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2CLK};
      dat_sync_q <= {dat_sync_q[0], PS2DATA};
      flt_cnt_q  <= flt_cnt_d;
      flt_q      <= flt_d;
      flt_prev_q <= flt_q;
      st_q       <= st_d;
      bit_q      <= bit_d;
      wd_q       <= wd_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // ---- stage: RX FIFO ----
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop     = rx_read && (cnt_q != '0);
  assign push_ok = rx_push && (!full || pop);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop)     rd_q <= rd_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (rx_push && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Datapath registers carry no reset; their contents are qualified by FSM state or FIFO count.
  always_ff @(posedge CLK) begin
    if (latch_tx)  tx_sr_q <= {~^datain, datain};
    if (rx_shift)  rx_sr_q <= {dat_s, rx_sr_q[7:1]};
    if (rx_par_ld) rx_par_q <= dat_s;
    if (push_ok)   mem_q[wr_q] <= rx_sr_q;
  end

  // ---- stage: outputs ----
  assign tx_busy    = (st_q != S_IDLE);
  assign tx_done    = tx_done_q;
  assign tx_err     = tx_err_q;
  assign rx_done    = rx_done_q;
  assign rx_err     = rx_err_q;
  assign rx_valid   = (cnt_q != '0);
  assign dataout    = rx_valid ? mem_q[rd_q] : 8'h00;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

`ifdef PS2_ERR_COUNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  logic [7:0] err_cnt_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                  err_cnt_q <= 8'h00;
    else if (tx_err_q || rx_err_q) err_cnt_q <= sat_inc8(err_cnt_q);
  end
  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
